// File: rtl/mpsoc_slave_arbiter_if.sv
// rtl/mpsoc_slave_arbiter_if.sv - master-side and shared-slave bus bundle for mpsoc_slave_arbiter
interface mpsoc_slave_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0]             m_readdata;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [ADDR_W-1:0]             s_address;
    logic                          s_read;
    logic                          s_write;
    logic [DATA_W-1:0]             s_writedata;
    logic [DATA_W-1:0]             s_readdata;
    logic                          s_waitrequest;
    logic [NUM_MASTERS-1:0]        grant;
    logic                          timeout_pulse;

    // Arbiter view: it is the target of the cores and the initiator toward the shared slave.
    modport slave (
        input  m_address, m_read, m_write, m_writedata, s_readdata, s_waitrequest,
        output m_readdata, m_waitrequest, s_address, s_read, s_write, s_writedata,
               grant, timeout_pulse
    );

    // Environment view: the cores plus the shared peripheral.
    modport master (
        output m_address, m_read, m_write, m_writedata, s_readdata, s_waitrequest,
        input  m_readdata, m_waitrequest, s_address, s_read, s_write, s_writedata,
               grant, timeout_pulse
    );
endinterface

// File: rtl/mpsoc_slave_arbiter.sv
// rtl/mpsoc_slave_arbiter.sv - round-robin arbiter sharing one Avalon-MM slave among NUM_MASTERS cores
module mpsoc_slave_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mpsoc_slave_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      s_address_q, s_address_d;
    logic                   s_read_q, s_read_d;
    logic                   s_write_q, s_write_d;
    logic [DATA_W-1:0]      s_writedata_q, s_writedata_d;
    logic [DATA_W-1:0]      m_readdata_q, m_readdata_d;
    logic [NUM_MASTERS-1:0] m_waitrequest_q, m_waitrequest_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]       pick;
    logic                   found;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
        end
        return IDX_W'(sum);
    endfunction

    assign req = bus.m_read | bus.m_write;

    // First requester at or after rr_q in circular order.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[wrap_add(rr_q, k)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_q, k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            rr_q            <= '0;
            owner_q         <= '0;
            cnt_q           <= '0;
            s_address_q     <= '0;
            s_read_q        <= 1'b0;
            s_write_q       <= 1'b0;
            s_writedata_q   <= '0;
            m_readdata_q    <= '0;
            m_waitrequest_q <= '1;
            grant_q         <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            owner_q         <= owner_d;
            cnt_q           <= cnt_d;
            s_address_q     <= s_address_d;
            s_read_q        <= s_read_d;
            s_write_q       <= s_write_d;
            s_writedata_q   <= s_writedata_d;
            m_readdata_q    <= m_readdata_d;
            m_waitrequest_q <= m_waitrequest_d;
            grant_q         <= grant_d;
            timeout_q       <= timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        owner_d         = owner_q;
        cnt_d           = cnt_q;
        s_address_d     = s_address_q;
        s_read_d        = s_read_q;
        s_write_d       = s_write_q;
        s_writedata_d   = s_writedata_q;
        m_readdata_d    = m_readdata_q;
        m_waitrequest_d = m_waitrequest_q;
        grant_d         = grant_q;
        timeout_d       = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d        = pick;
                    cnt_d          = '0;
                    s_address_d    = bus.m_address[int'(pick)*ADDR_W +: ADDR_W];
                    s_writedata_d  = bus.m_writedata[int'(pick)*DATA_W +: DATA_W];
                    // A simultaneous read and write is treated as a read.
                    s_read_d       = bus.m_read[pick];
                    s_write_d      = bus.m_write[pick] & ~bus.m_read[pick];
                    grant_d        = '0;
                    grant_d[pick]  = 1'b1;
                    state_d        = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.s_waitrequest) begin
                    if (s_read_q) begin
                        m_readdata_d = bus.s_readdata;
                    end
                    s_read_d                 = 1'b0;
                    s_write_d                = 1'b0;
                    m_waitrequest_d[owner_q] = 1'b0;
                    rr_d                     = wrap_add(owner_q, 1);
                    state_d                  = DONE;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    // Abort: the command has been held for exactly TIMEOUT stalled cycles.
                    m_readdata_d             = '0;
                    timeout_d                = 1'b1;
                    s_read_d                 = 1'b0;
                    s_write_d                = 1'b0;
                    m_waitrequest_d[owner_q] = 1'b0;
                    rr_d                     = wrap_add(owner_q, 1);
                    state_d                  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                m_waitrequest_d = '1;
                grant_d         = '0;
                timeout_d       = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_address     = s_address_q;
    assign bus.s_read        = s_read_q;
    assign bus.s_write       = s_write_q;
    assign bus.s_writedata   = s_writedata_q;
    assign bus.m_readdata    = m_readdata_q;
    assign bus.m_waitrequest = m_waitrequest_q;
    assign bus.grant         = grant_q;
    assign bus.timeout_pulse = timeout_q;
endmodule

// File: tb/tb_mpsoc_slave_arbiter.sv
// tb/tb_mpsoc_slave_arbiter.sv - scoreboard bench for mpsoc_slave_arbiter with a behavioural slave
module tb_mpsoc_slave_arbiter;
    localparam int NM = 4;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic [AW-1:0] addr;
        int            cmd;    // 0 read, 1 write, 2 read+write
        logic [DW-1:0] wdata;
        int            stall;
    } acc_t;

    typedef struct {
        int            master;
        bit            is_read;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            tmo;
        int            cycles;
        bit            b2b;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mpsoc_slave_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mpsoc_slave_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t          expq[$];
    int            stallq[$];
    acc_t          mtab[NM][4];
    int            rcount[NM];
    logic [DW-1:0] ref_mem[16];
    logic [DW-1:0] slv_mem[16];
    int            model_ptr = 0;
    logic [DW-1:0] model_rdata = '0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // Shared slave: stalls each access by the queued count, commits writes on acceptance.
    bit            r_active = 1'b0;
    int            r_stall = 0;
    int            r_waited = 0;
    bit            r_commit = 1'b0;
    logic [AW-1:0] r_caddr;
    logic [DW-1:0] r_cdata;

    initial begin
        bus.s_waitrequest = 1'b1;
        bus.s_readdata    = '0;
        forever begin
            @(posedge clock);
            #1;
            if (r_commit) slv_mem[r_caddr] = r_cdata;
            r_commit = 1'b0;
            if (!(bus.s_read || bus.s_write)) begin
                r_active          = 1'b0;
                bus.s_waitrequest = 1'b1;
                bus.s_readdata    = $urandom;
            end else begin
                if (!r_active) begin
                    r_active = 1'b1;
                    r_waited = 0;
                    r_stall  = (stallq.size() > 0) ? stallq.pop_front() : 0;
                end
                if (r_waited < r_stall) begin
                    bus.s_waitrequest = 1'b1;
                    bus.s_readdata    = $urandom;
                    r_waited++;
                end else begin
                    bus.s_waitrequest = 1'b0;
                    bus.s_readdata    = slv_mem[bus.s_address];
                    if (bus.s_write) begin
                        r_commit = 1'b1;
                        r_caddr  = bus.s_address;
                        r_cdata  = bus.s_writedata;
                    end
                end
            end
        end
    end

    // Monitor: follows the slave-side access and pops the scoreboard on each completion.
    bit            m_active = 1'b0;
    bit            m_prev_done = 1'b0;
    bit            m_bus_ok = 1'b1;
    int            m_cyc = 0;
    int            m_t = 0;
    int            m_done_t = 0;
    exp_t          m_cur;
    exp_t          m_e;
    logic [NM-1:0] m_wexp;
    logic [NM-1:0] m_gexp;

    always @(negedge clock) begin
        if (!mon_en) begin
            m_active    = 1'b0;
            m_prev_done = 1'b0;
        end else begin
            m_t++;
            if (m_prev_done) begin
                chk("post_done_waitreq", 64'(bus.m_waitrequest), 64'hF);
                chk("post_done_grant", 64'(bus.grant), 64'h0);
                chk("post_done_tpulse", 64'(bus.timeout_pulse), 64'h0);
                m_prev_done = 1'b0;
            end
            if ((bus.s_read || bus.s_write) && !m_active) begin
                m_active = 1'b1;
                m_cyc    = 0;
                m_bus_ok = 1'b1;
                if (expq.size() == 0) begin
                    fail("unexpected_access");
                end else begin
                    m_cur = expq[0];
                    if (m_cur.b2b) chk("b2b_gap", 64'(m_t - m_done_t), 64'd2);
                end
            end
            if (m_active && (bus.s_read || bus.s_write)) begin
                m_cyc++;
                m_gexp = '0;
                m_gexp[m_cur.master] = 1'b1;
                if (bus.s_read !== m_cur.is_read || bus.s_write !== !m_cur.is_read ||
                    bus.s_address !== m_cur.addr || bus.s_writedata !== m_cur.wdata ||
                    bus.grant !== m_gexp)
                    m_bus_ok = 1'b0;
            end
            if (bus.m_waitrequest !== '1) begin
                if (expq.size() == 0) begin
                    fail("unexpected_completion");
                end else begin
                    m_e    = expq.pop_front();
                    m_wexp = '1;
                    m_wexp[m_e.master] = 1'b0;
                    m_gexp = '0;
                    m_gexp[m_e.master] = 1'b1;
                    chk("owner_waitreq", 64'(bus.m_waitrequest), 64'(m_wexp));
                    chk("rdata", 64'(bus.m_readdata), 64'(m_e.rdata));
                    chk("tpulse", 64'(bus.timeout_pulse), 64'(m_e.tmo));
                    chk("grant_done", 64'(bus.grant), 64'(m_gexp));
                    chk("access_cycles", 64'(m_cyc), 64'(m_e.cycles));
                    chk("bus_stable", 64'(m_bus_ok), 64'h1);
                end
                m_active    = 1'b0;
                m_prev_done = 1'b1;
                m_done_t    = m_t;
            end
        end
    end

    task automatic drive_master(input int i, input acc_t a);
        bus.m_address[i*AW +: AW]   = a.addr;
        bus.m_writedata[i*DW +: DW] = a.wdata;
        bus.m_read[i]  = (a.cmd != 1);
        bus.m_write[i] = (a.cmd != 0);
    endtask

    task automatic idle_master(input int i);
        bus.m_read[i]  = 1'b0;
        bus.m_write[i] = 1'b0;
        bus.m_address[i*AW +: AW]   = AW'($urandom);
        bus.m_writedata[i*DW +: DW] = $urandom;
    endtask

    task automatic set_acc(input int i, input int j, input int addr, input int cmd,
                           input logic [DW-1:0] wdata, input int stall);
        mtab[i][j].addr  = AW'(addr);
        mtab[i][j].cmd   = cmd;
        mtab[i][j].wdata = wdata;
        mtab[i][j].stall = stall;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NM; i++) rcount[i] = 0;
    endtask

    // Reference: serve pending masters in circular order from the pointer, one access each turn.
    task automatic run_round(input int limit);
        int   rem[NM];
        int   idx[NM];
        int   pos[NM];
        bit   act[NM];
        int   total;
        int   m;
        int   c;
        int   cyc;
        bit   busy;
        bit   first;
        acc_t a;
        exp_t e;
        total = 0;
        for (int i = 0; i < NM; i++) begin
            rem[i] = rcount[i];
            idx[i] = 0;
            total += rcount[i];
        end
        first = 1'b1;
        while (total > 0) begin
            m = -1;
            for (int k = 0; k < NM; k++) begin
                c = (model_ptr + k) % NM;
                if (m < 0 && rem[c] > 0) m = c;
            end
            a = mtab[m][idx[m]];
            idx[m]++;
            rem[m]--;
            total--;
            e.master  = m;
            e.is_read = (a.cmd != 1);
            e.addr    = a.addr;
            e.wdata   = a.wdata;
            e.tmo     = (a.stall >= TO);
            e.cycles  = e.tmo ? TO : a.stall + 1;
            if (e.tmo) model_rdata = '0;
            else if (e.is_read) model_rdata = ref_mem[a.addr];
            else ref_mem[a.addr] = a.wdata;
            e.rdata = model_rdata;
            e.b2b   = !first;
            first   = 1'b0;
            expq.push_back(e);
            stallq.push_back(a.stall);
            model_ptr = (m + 1) % NM;
        end
        for (int i = 0; i < NM; i++) begin
            pos[i] = 0;
            act[i] = (rcount[i] > 0);
            if (act[i]) drive_master(i, mtab[i][0]);
            else idle_master(i);
        end
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < limit) begin
            @(negedge clock);
            cyc++;
            busy = 1'b0;
            for (int i = 0; i < NM; i++) begin
                if (act[i] && bus.m_waitrequest[i] == 1'b0) begin
                    pos[i]++;
                    if (pos[i] < rcount[i]) drive_master(i, mtab[i][pos[i]]);
                    else begin
                        act[i] = 1'b0;
                        idle_master(i);
                    end
                end
                if (act[i]) busy = 1'b1;
            end
        end
        if (busy) begin
            fail("round_timeout");
            for (int i = 0; i < NM; i++) idle_master(i);
        end
        repeat (3) @(negedge clock);
        chk("round_drained", 64'(expq.size()), 64'h0);
        expq.delete();
        stallq.delete();
    endtask

    int            lows;
    int            wcnt;
    logic [DW-1:0] v;

    initial begin
        for (int a = 0; a < 16; a++) begin
            v = $urandom;
            ref_mem[a] = v;
            slv_mem[a] = v;
        end
        ref_mem[5] = 32'h694E10E8;
        slv_mem[5] = 32'h694E10E8;
        for (int i = 0; i < NM; i++) idle_master(i);

        bus.m_read = '1;
        reset_n    = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_waitreq", 64'(bus.m_waitrequest), 64'hF);
        chk("reset_grant", 64'(bus.grant), 64'h0);
        chk("reset_s_read", 64'(bus.s_read), 64'h0);
        chk("reset_s_write", 64'(bus.s_write), 64'h0);
        chk("reset_rdata", 64'(bus.m_readdata), 64'h0);
        chk("reset_tpulse", 64'(bus.timeout_pulse), 64'h0);
        bus.m_read = '0;
        reset_n    = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;

        clear_counts();
        rcount = '{2, 1, 1, 1};
        for (int i = 0; i < NM; i++)
            for (int j = 0; j < 2; j++) set_acc(i, j, $urandom_range(0, 15), 0, $urandom, 0);
        run_round(200);

        clear_counts();
        rcount[1] = 1;
        set_acc(1, 0, 3, 1, 32'hCAFE0001, 5);
        run_round(200);

        clear_counts();
        rcount[2] = 1;
        set_acc(2, 0, 5, 0, $urandom, 0);
        run_round(200);

        clear_counts();
        rcount[3] = 1;
        set_acc(3, 0, $urandom_range(0, 15), 0, $urandom, 0);
        run_round(200);

        clear_counts();
        rcount[0] = 1;
        rcount[3] = 1;
        set_acc(0, 0, 7, 0, $urandom, 20);
        set_acc(3, 0, 9, 0, $urandom, 20);
        run_round(200);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NM; i++) begin
                rcount[i] = 0;
                for (int j = 0; j < 4; j++)
                    set_acc(i, j, $urandom_range(0, 15), $urandom_range(0, 2), $urandom,
                            ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(5, 12));
            end
            while (rcount[0] + rcount[1] + rcount[2] + rcount[3] == 0)
                for (int i = 0; i < NM; i++) rcount[i] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : 0;
            run_round(2000);
        end

        clear_counts();
        rcount[1] = 1;
        set_acc(1, 0, 4, 0, $urandom, 1);
        run_round(200);

        mon_en = 1'b0;
        @(negedge clock);
        set_acc(3, 0, 2, 0, $urandom, 30);
        stallq.push_back(30);
        drive_master(3, mtab[3][0]);
        wcnt = 0;
        while (!bus.s_read && wcnt < 20) begin
            @(negedge clock);
            wcnt++;
        end
        chk("mid_granted", 64'(bus.s_read), 64'h1);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        idle_master(3);
        @(negedge clock);
        chk("mid_reset_s_read", 64'(bus.s_read), 64'h0);
        chk("mid_reset_grant", 64'(bus.grant), 64'h0);
        chk("mid_reset_waitreq", 64'(bus.m_waitrequest), 64'hF);
        lows = 0;
        @(negedge clock);
        if (bus.m_waitrequest !== '1) lows++;
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (bus.m_waitrequest !== '1) lows++;
        end
        chk("no_pulse_on_reset", 64'(lows), 64'h0);
        chk("mid_reset_rdata", 64'(bus.m_readdata), 64'h0);
        stallq.delete();
        expq.delete();
        model_ptr   = 0;
        model_rdata = '0;
        mon_en      = 1'b1;

        clear_counts();
        rcount[1] = 1;
        rcount[3] = 1;
        set_acc(1, 0, 6, 0, $urandom, 0);
        set_acc(3, 0, 8, 0, $urandom, 0);
        run_round(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
